// File: rtl/ledplay_pkg.sv
// Board-level constants shared by the LED/seven-segment playground blocks.
package ledplay_pkg;
  localparam int SW_WIDTH          = 3;
  localparam int SW_DEBOUNCE_CNT_W = 16;
endpackage

// File: rtl/switch_debouncer_channel.sv
// One switch channel: two-flop synchroniser, stability counter, debounced
// level and registered rise/fall pulses.
module debounce_channel #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_full;
  logic             w_accept;

  assign w_diff   = r_sync ^ r_level;
  assign w_full   = &r_cnt;
  assign w_accept = w_diff & w_full;

  // r_meta is the only flop allowed to see the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= sw_in;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_accept & r_sync;
      r_fall <= w_accept & ~r_sync;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (!w_full) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end
    end
  end

  assign sw_level = r_level;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;
  assign accept   = w_accept;
endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide switches independently; sw_changed flags any
// accepted edge in the same cycle as the per-bit pulses.
module switch_debouncer
  import ledplay_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int CNT_W = SW_DEBOUNCE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);
  logic [WIDTH-1:0] w_accept;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_in    (sw_in[g]),
      .sw_level (sw_level[g]),
      .sw_rise  (sw_rise[g]),
      .sw_fall  (sw_fall[g]),
      .accept   (w_accept[g])
    );
  end

  // Any acceptance this edge means a rise or fall pulse next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_changed <= 1'b0;
    else        r_changed <= |w_accept;
  end

  assign sw_changed = r_changed;
endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer (WIDTH=3, CNT_W=2)
// with a run-length reference model and an expected-output queue.
module tb_switch_debouncer;
  localparam int W     = 3;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << CW;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_level;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int checks;
  int errors;
  logic [3*W:0] exp_q[$];
  bit           done;

  switch_debouncer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .sw_level   (sw_level),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pin values pass through a two-entry delay line; a channel's level flips
  // once its delayed value has disagreed with it for DEPTH cycles in a row.
  logic [W-1:0] m_stage1, m_stage2, m_level;
  int           m_run[W];

  task automatic model_reset();
    m_stage1 = '0;
    m_stage2 = '0;
    m_level  = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] rise, fall;
    rise = '0;
    fall = '0;
    for (int i = 0; i < W; i++) begin
      if (m_stage2[i] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEPTH) begin
          m_level[i] = m_stage2[i];
          rise[i]    = m_stage2[i];
          fall[i]    = ~m_stage2[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_stage2 = m_stage1;
    m_stage1 = sw_in;
    exp_q.push_back({m_level, rise, fall, |(rise | fall)});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [3*W:0] act, input logic [3*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got lvl=%b rise=%b fall=%b chg=%b, expected lvl=%b rise=%b fall=%b chg=%b",
               name, $time, act[3*W:2*W+1], act[2*W:W+1], act[W:1], act[0],
               exp[3*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
    end
  endtask

  initial begin
    logic [3*W:0] exp;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (!rst_n) begin
          exp_q.delete();
          check("in_reset", {sw_level, sw_rise, sw_fall, sw_changed}, '0);
        end else if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("cycle", {sw_level, sw_rise, sw_fall, sw_changed}, exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic hold(input logic [W-1:0] v, input int cycles);
    sw_in = v;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  int rise_pulses2;
  always @(negedge clk) if (rst_n && sw_rise[2]) rise_pulses2++;

  initial begin
    int n_before;
    logic [W-1:0] v;
    checks = 0;
    errors = 0;
    done   = 1'b0;
    rise_pulses2 = 0;
    sw_in  = '1;
    rst_n  = 1'b0;

    // Switches high through reset: outputs stay 0, then all rise together.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    hold(3'b111, 10);

    // All fall, then a clean single-bit rise.
    hold(3'b000, 10);
    hold(3'b001, 10);

    // Short glitch on bit 1 must be rejected.
    hold(3'b011, 3);
    hold(3'b001, 10);

    // Bounce on bit 2, then settle high: exactly one rise pulse.
    n_before = rise_pulses2;
    hold(3'b101, 1);
    hold(3'b001, 1);
    hold(3'b101, 1);
    hold(3'b001, 1);
    hold(3'b101, 12);
    checks++;
    if (rise_pulses2 - n_before != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d pulses, expected 1", rise_pulses2 - n_before);
    end

    // Reach 011, then a simultaneous rise (bit 2) and double fall.
    hold(3'b011, 10);
    hold(3'b100, 10);

    // Reset two counts into a pending change on bit 1: immediate clear.
    sw_in = 3'b110;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {sw_level, sw_rise, sw_fall, sw_changed}, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    hold(3'b110, 10);

    // Randomised holds of random patterns, some shorter than the window.
    for (int t = 0; t < 60; t++) begin
      v = W'($urandom_range(0, (1 << W) - 1));
      hold(v, $urandom_range(1, 8));
    end
    hold(3'b000, 12);

    done = 1'b1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL queue_drain: %0d expected entries left, expected at most 1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
